// File: rtl/wb_pkg.sv
// Shared write-back select definitions: requester count, mux select encodings
// and the helper that advances a select index with wrap from 2 back to 0.
package wb_pkg;

  localparam int N_SRC = 3;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_ALU  = 2'd0;
  localparam sel_t SEL_MEM  = 2'd1;
  localparam sel_t SEL_LINK = 2'd2;

  function automatic sel_t next_sel(input sel_t s);
    return (s == SEL_LINK) ? SEL_ALU : sel_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/wb_sel_arbiter_if.sv
// Write-back arbitration bundle between the requesters (master) and the
// select arbiter (slave); the arbiter drives grant, select and write enable.
interface wb_sel_arbiter_if;
  import wb_pkg::*;

  logic [N_SRC-1:0] REQ;
  logic             HOLD;
  logic [N_SRC-1:0] GNT;
  sel_t             S;
  logic             WE;
  logic             BUSY;

  modport master (output REQ, HOLD, input GNT, S, WE, BUSY);
  modport slave  (input REQ, HOLD, output GNT, S, WE, BUSY);

endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: first eligible requester found
// scanning from the priority pointer upward, wrapping 2 -> 0.
module rr_pick3
  import wb_pkg::*;
(
  input  logic [N_SRC-1:0] i_eligible,
  input  sel_t             i_ptr,
  output sel_t             o_win,
  output logic [N_SRC-1:0] o_onehot,
  output logic             o_valid
);

  always_comb begin
    sel_t w_idx;
    o_win    = SEL_ALU;
    o_onehot = '0;
    o_valid  = 1'b0;
    w_idx    = i_ptr;
    // Only the first hit along the rotated scan order may claim the win.
    for (int k = 0; k < N_SRC; k++) begin
      if (!o_valid && i_eligible[w_idx]) begin
        o_valid  = 1'b1;
        o_win    = w_idx;
        o_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << w_idx;
      end
      w_idx = next_sel(w_idx);
    end
  end

endmodule

// File: rtl/wb_sel_arbiter.sv
// Round-robin write-back select controller: registers a one-hot grant, the
// mux select and the register-file write enable for three requesters.
module wb_sel_arbiter #(
  parameter int N_SRC = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  wb_sel_arbiter_if.slave   bus
);
  import wb_pkg::*;

  logic [N_SRC-1:0] r_gnt;
  sel_t             r_s;
  sel_t             r_ptr;
  logic             r_we;
  logic             r_busy;

  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_onehot;
  logic [N_SRC-1:0] w_grant;
  sel_t             w_win;
  logic             w_valid;
  logic             w_take;

  // Last cycle's grantee sits out one cycle so a requester still holding REQ
  // through its GNT cycle is not granted twice for the same write.
  assign w_eligible = bus.REQ & ~r_gnt;

  rr_pick3 u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_win      (w_win),
    .o_onehot   (w_onehot),
    .o_valid    (w_valid)
  );

  assign w_take  = w_valid & ~bus.HOLD;
  assign w_grant = w_take ? w_onehot : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gnt  <= '0;
      r_s    <= SEL_ALU;
      r_ptr  <= SEL_ALU;
      r_we   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= |(w_eligible & ~w_grant);
      if (w_take) begin
        r_gnt <= w_onehot;
        r_s   <= w_win;
        r_we  <= 1'b1;
        r_ptr <= next_sel(w_win);
      end else begin
        r_gnt <= '0;
        r_we  <= 1'b0;
      end
    end
  end

  assign bus.GNT  = r_gnt;
  assign bus.S    = r_s;
  assign bus.WE   = r_we;
  assign bus.BUSY = r_busy;

endmodule

// File: tb/tb_wb_sel_arbiter.sv
// Scoreboard bench for wb_sel_arbiter: a reference model queues the expected
// outputs at each edge and a monitor compares them half a cycle later.
module tb_wb_sel_arbiter;
  import wb_pkg::*;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] s;
    logic       we;
    logic       busy;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  wb_sel_arbiter_if bus();

  wb_sel_arbiter dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  exp_t       expQ[$];
  int         errors = 0;
  int         checks = 0;
  int         mPtr   = 0;
  int         mS     = 0;
  logic [2:0] mGnt   = 3'b000;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_GNT"},  32'(bus.GNT),  32'd0);
    checkOutput({name, "_WE"},   32'(bus.WE),   32'd0);
    checkOutput({name, "_S"},    32'(bus.S),    32'd0);
    checkOutput({name, "_BUSY"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic hold, input int n);
    repeat (n) begin
      @(negedge CLK);
      bus.REQ  = req;
      bus.HOLD = hold;
    end
  endtask

  task automatic randomReset();
    @(posedge CLK);
    #($urandom_range(1, 4));
    RST_N = 1'b0;
    #1;
    checkReset("rand_rst");
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Reference model: eligible = requests minus last grantee, scan from the
  // pointer modulo 3, and the pointer moves just past the winner.
  always @(posedge CLK) begin
    if (RST_N) begin
      logic [2:0] e;
      int         win;
      exp_t       x;
      e   = bus.REQ & ~mGnt;
      win = -1;
      if (!bus.HOLD) begin
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (mPtr + k) % 3;
          if (win < 0 && e[i]) win = i;
        end
      end
      x.busy = 1'b0;
      for (int i = 0; i < 3; i++)
        if (e[i] && i != win) x.busy = 1'b1;
      if (win >= 0) begin
        mGnt = 3'b001 << win;
        mS   = win;
        mPtr = (win + 1) % 3;
      end else begin
        mGnt = 3'b000;
      end
      x.gnt = mGnt;
      x.s   = mS[1:0];
      x.we  = (win >= 0);
      expQ.push_back(x);
    end
  end

  always @(negedge RST_N) begin
    expQ.delete();
    mPtr = 0;
    mS   = 0;
    mGnt = 3'b000;
  end

  always @(negedge CLK) begin
    if (RST_N && expQ.size() > 0) begin
      exp_t x;
      x = expQ.pop_front();
      checkOutput("GNT",    32'(bus.GNT),          32'(x.gnt));
      checkOutput("S",      32'(bus.S),            32'(x.s));
      checkOutput("WE",     32'(bus.WE),           32'(x.we));
      checkOutput("BUSY",   32'(bus.BUSY),         32'(x.busy));
      checkOutput("S_not3", 32'(bus.S == 2'd3),    32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.REQ  = 3'b111;
    bus.HOLD = 1'b0;
    repeat (2) @(negedge CLK);
    checkReset("por");
    RST_N = 1'b1;

    // Contention from reset gives S = 0,1,2; reset lands while S=2, WE=1.
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("pre_rst_S",  32'(bus.S),  32'd2);
    checkOutput("pre_rst_WE", 32'(bus.WE), 32'd1);
    RST_N = 1'b0;
    #1;
    checkReset("mid_write");
    @(negedge CLK);
    RST_N = 1'b1;

    applyStimulus(3'b111, 1'b0, 6);
    applyStimulus(3'b010, 1'b0, 6);
    applyStimulus(3'b000, 1'b0, 1);
    applyStimulus(3'b010, 1'b0, 1);
    applyStimulus(3'b101, 1'b0, 3);
    applyStimulus(3'b111, 1'b1, 4);
    applyStimulus(3'b111, 1'b0, 4);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0)
        randomReset();
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1);
    end

    applyStimulus(3'b000, 1'b0, 3);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
